// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the single SDRAM controller port between camera burst writes and display
// burst reads, and manages the two-bank ping-pong frame store addressing.
module sdram_frame_arbiter #(
   parameter int unsigned BURST_LEN   = 64,
   parameter int unsigned FRAME_WORDS = 1024*600,
   parameter int unsigned OFS_W       = 20,
   parameter int unsigned LVL_W       = 10
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic             I_sdrc_init_done,
   input  logic             I_wr_vsync,
   input  logic             I_rd_vsync,
   input  logic [LVL_W-1:0] I_wr_fifo_level,
   input  logic [LVL_W-1:0] I_rd_fifo_level,
   output logic             O_wr_fifo_rd,
   output logic             O_rd_fifo_wr,
   output logic             O_sdrc_wr_n,
   output logic             O_sdrc_rd_n,
   output logic [OFS_W:0]   O_sdrc_addr,
   input  logic             I_sdrc_busy_n,
   input  logic             I_sdrc_rd_valid,
   output logic             O_wr_bank,
   output logic             O_rd_bank,
   output logic             O_err
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [LVL_W:0]   DEPTH     = {1'b1, {LVL_W{1'b0}}};
   localparam logic [LVL_W:0]   BL_LVL    = (LVL_W+1)'(BURST_LEN);
   localparam logic [OFS_W:0]   BL_OFS    = (OFS_W+1)'(BURST_LEN);
   localparam logic [OFS_W:0]   FRM_OFS   = (OFS_W+1)'(FRAME_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_CMD, S_WR_DATA, S_WAIT_ACK, S_RD_CMD, S_RD_DATA, S_WAIT_IDLE
   } state_t;

   state_t           state, state_n;
   logic [2:0]       wr_vs_sr, rd_vs_sr;
   logic             wr_rise, rd_rise, pw, pr;
   logic             wr_bank, rd_bank, done_bank, last_wr;
   logic [OFS_W-1:0] wr_ofs, rd_ofs;
   logic [CNT_W-1:0] beat_cnt;
   logic             busy_seen, in_idle;
   logic             wreq, rreq, urgent, ready, grant_rd, grant_wr;
   logic             wr_bank_n, rd_bank_n, done_bank_n;
   logic [OFS_W-1:0] wr_ofs_n, rd_ofs_n, wr_ofs_adv, rd_ofs_adv;
   logic [OFS_W:0]   wr_sum, rd_sum;

   assign wr_rise   = wr_vs_sr[1] & ~wr_vs_sr[2];
   assign rd_rise   = rd_vs_sr[1] & ~rd_vs_sr[2];
   assign in_idle   = (state == S_IDLE);
   assign O_wr_bank = wr_bank;
   assign O_rd_bank = rd_bank;

   // Pending vsync flags resolve in IDLE ahead of arbitration; pw before pr so a
   // simultaneous display vsync picks up the frame that just completed.
   always_comb begin
      wr_bank_n   = wr_bank;
      wr_ofs_n    = wr_ofs;
      done_bank_n = done_bank;
      rd_bank_n   = rd_bank;
      rd_ofs_n    = rd_ofs;
      if (in_idle && pw) begin
         wr_bank_n   = ~wr_bank;
         wr_ofs_n    = '0;
         done_bank_n = wr_bank;
      end
      if (in_idle && pr) begin
         rd_bank_n = done_bank_n;
         rd_ofs_n  = '0;
      end
      wr_sum     = {1'b0, wr_ofs} + BL_OFS;
      rd_sum     = {1'b0, rd_ofs} + BL_OFS;
      wr_ofs_adv = (wr_sum == FRM_OFS) ? '0 : wr_sum[OFS_W-1:0];
      rd_ofs_adv = (rd_sum == FRM_OFS) ? '0 : rd_sum[OFS_W-1:0];
   end

   always_comb begin
      wreq     = ({1'b0, I_wr_fifo_level} >= BL_LVL);
      rreq     = ((DEPTH - {1'b0, I_rd_fifo_level}) >= BL_LVL);
      urgent   = ({1'b0, I_rd_fifo_level} < BL_LVL);
      ready    = I_sdrc_init_done & I_sdrc_busy_n;
      grant_rd = urgent | (rreq & (~wreq | last_wr));
      grant_wr = ~grant_rd & wreq;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (ready && grant_rd)      state_n = S_RD_CMD;
            else if (ready && grant_wr) state_n = S_WR_CMD;
         end
         S_WR_CMD:    state_n = S_WR_DATA;
         S_WR_DATA:   if (beat_cnt == LAST_BEAT) state_n = S_WAIT_ACK;
         S_WAIT_ACK:  if (!I_sdrc_busy_n) state_n = S_WAIT_IDLE;
         S_RD_CMD:    state_n = S_RD_DATA;
         S_RD_DATA:   if (I_sdrc_rd_valid && beat_cnt == LAST_BEAT) state_n = S_WAIT_IDLE;
         S_WAIT_IDLE: if (I_sdrc_busy_n) state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   always_comb begin
      O_sdrc_wr_n  = (state != S_WR_CMD);
      O_sdrc_rd_n  = (state != S_RD_CMD);
      O_wr_fifo_rd = (state == S_WR_DATA);
      O_rd_fifo_wr = (state == S_RD_DATA) & I_sdrc_rd_valid;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) state <= S_IDLE;
      else          state <= state_n;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         wr_vs_sr    <= '0;
         rd_vs_sr    <= '0;
         pw          <= 1'b0;
         pr          <= 1'b0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b1;
         done_bank   <= 1'b1;
         last_wr     <= 1'b0;
         wr_ofs      <= '0;
         rd_ofs      <= '0;
         beat_cnt    <= '0;
         busy_seen   <= 1'b0;
         O_sdrc_addr <= '0;
         O_err       <= 1'b0;
      end else begin
         wr_vs_sr  <= {wr_vs_sr[1:0], I_wr_vsync};
         rd_vs_sr  <= {rd_vs_sr[1:0], I_rd_vsync};
         pw        <= wr_rise | (pw & ~in_idle);
         pr        <= rd_rise | (pr & ~in_idle);
         busy_seen <= in_idle & ~I_sdrc_busy_n;
         if ((I_sdrc_rd_valid && state != S_RD_DATA) ||
             (busy_seen && in_idle && !I_sdrc_busy_n))
            O_err <= 1'b1;
         unique case (state)
            S_IDLE: begin
               wr_bank   <= wr_bank_n;
               wr_ofs    <= wr_ofs_n;
               done_bank <= done_bank_n;
               rd_bank   <= rd_bank_n;
               rd_ofs    <= rd_ofs_n;
               beat_cnt  <= '0;
               if (state_n == S_WR_CMD) begin
                  O_sdrc_addr <= {wr_bank_n, wr_ofs_n};
                  last_wr     <= 1'b1;
               end else if (state_n == S_RD_CMD) begin
                  O_sdrc_addr <= {rd_bank_n, rd_ofs_n};
                  last_wr     <= 1'b0;
               end
            end
            S_WR_DATA: begin
               beat_cnt <= beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) wr_ofs <= wr_ofs_adv;
            end
            S_RD_DATA: begin
               if (I_sdrc_rd_valid) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) rd_ofs <= rd_ofs_adv;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sdram_frame_arbiter.md
# sdram_frame_arbiter

Shares the single SDRAM controller port between the camera write path and the display read path of the SDRAM frame buffer. Issues one-cycle active-low burst commands to the SDRAM controller, paces the write-FIFO pop and read-FIFO push strobes, and generates burst addresses. Manages a two-bank (ping-pong) frame store: camera vsync switches the write bank, and display vsync selects the last completed bank for reading. Sits between the vin/vout FIFOs and the SDRAM controller, in the memory clock domain.

## Interface
- BURST_LEN, 64: words per SDRAM burst; power of two, ≥4.
- FRAME_WORDS, 1024*600: words per frame; integer multiple of BURST_LEN.
- OFS_W, 20: frame offset width; 2^OFS_W ≥ FRAME_WORDS.
- LVL_W, 10: FIFO level width; FIFO depth = 2^LVL_W ≥ 2*BURST_LEN.
- I_clk  in  1  memory clock; all logic on its rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_sdrc_init_done  in  1  controller calibrated; no command issued while 0.
- I_wr_vsync  in  1  camera vsync; asynchronous; 2-flop synchronized inside.
- I_rd_vsync  in  1  display vsync; asynchronous; 2-flop synchronized inside.
- I_wr_fifo_level  in  LVL_W  words held in the camera write FIFO.
- I_rd_fifo_level  in  LVL_W  words held in the display read FIFO.
- O_wr_fifo_rd  out  1  pop strobe to the write FIFO (show-ahead).
- O_rd_fifo_wr  out  1  push strobe to the read FIFO.
- O_sdrc_wr_n  out  1  burst-write command, one-cycle low pulse.
- O_sdrc_rd_n  out  1  burst-read command, one-cycle low pulse.
- O_sdrc_addr  out  OFS_W+1  {bank, word offset}.
- I_sdrc_busy_n  in  1  controller idle when 1.
- I_sdrc_rd_valid  in  1  read data beat valid.
- O_wr_bank  out  1  bank currently being written.
- O_rd_bank  out  1  bank currently being read.
- O_err  out  1  sticky protocol error.

## Operation
- Write request (wreq): I_wr_fifo_level ≥ BURST_LEN.
- Read request (rreq): 2^LVL_W − I_rd_fifo_level ≥ BURST_LEN.
- Urgent read: I_rd_fifo_level < BURST_LEN.
- Arbitration in IDLE, granted only when I_sdrc_init_done=1 and I_sdrc_busy_n=1:
  - Urgent read beats everything.
  - Otherwise, if both requests are pending, grant the side not granted last (last_grant reset = read, so the first tie goes to write).
  - Otherwise grant the single requester.
- FSM states: IDLE → WR_CMD → WR_DATA → WAIT_ACK → WAIT_IDLE → IDLE, and IDLE → RD_CMD → RD_DATA → WAIT_IDLE → IDLE.
  - WR_CMD: O_sdrc_wr_n=0 for one cycle; O_sdrc_addr = {wr_bank, wr_ofs}.
  - WR_DATA: O_wr_fifo_rd=1 for exactly BURST_LEN consecutive cycles.
  - WAIT_ACK: wait for I_sdrc_busy_n=0.
  - RD_CMD: O_sdrc_rd_n=0 for one cycle; O_sdrc_addr = {rd_bank, rd_ofs}.
  - RD_DATA: O_rd_fifo_wr = I_sdrc_rd_valid (combinational). Leave when the beat count reaches BURST_LEN.
  - WAIT_IDLE: wait for I_sdrc_busy_n=1.
- Offset update: wr_ofs/rd_ofs += BURST_LEN at burst end. When the result equals FRAME_WORDS, it wraps to 0 in the same bank (overrun camera frames overwrite; display repeats the frame).
- Write vsync rising edge: set the pending flag pw. Read vsync rising edge: set the pending flag pr.
- Pending flags are applied only in IDLE, before arbitration:
  - pw: wr_bank toggles, wr_ofs=0, done_bank = old wr_bank.
  - pr: rd_bank = done_bank, rd_ofs=0.
  - Both pending in the same cycle: apply pw first, so the read uses the just-completed bank.
- O_err is set by:
  - I_sdrc_rd_valid outside RD_DATA (the beat is not pushed).
  - I_sdrc_busy_n=0 in IDLE for more than 1 cycle while no command is outstanding.
- O_err is cleared only by reset.

## Timing
- Reset values:
  - O_sdrc_wr_n=1, O_sdrc_rd_n=1.
  - O_wr_fifo_rd=0, O_rd_fifo_wr=0, O_sdrc_addr=0, O_err=0.
  - wr_bank=0, rd_bank=1, done_bank=1.
  - Offsets 0, FSM in IDLE, pw=0, pr=0.
- Reset asserted mid-burst: all outputs return to reset values immediately; no completion is attempted.
- Request to command latency: 1 cycle (IDLE decision registered, command in the next cycle).
- Write burst: O_wr_fifo_rd is high from cycle C+1 through C+BURST_LEN, where C is the O_sdrc_wr_n low cycle.
- O_sdrc_addr holds valid from the command cycle until the next command.
- vsync to flag latency: 3 cycles (2-flop synchronizer plus edge register). A vsync edge during a burst is held until IDLE and is never lost. Only one pending edge is kept; a second edge before IDLE has no further effect.
- Minimum gap between bursts: 1 IDLE cycle after WAIT_IDLE.

## Test plan
- Reset, then I_sdrc_init_done=0 with both FIFOs requesting → no command pulses and all outputs at reset values. Set init_done=1 → O_sdrc_wr_n low within 2 cycles, addr=0x000000.
- Write FIFO level 64 only → one wr_n pulse, then 64 O_wr_fifo_rd cycles, then the next burst at offset 64 (addr 0x000040).
- Both requesting, read FIFO level 512 → grants alternate W,R,W,R. Drop read FIFO level to 10 → read granted next regardless of last_grant.
- Camera vsync mid-write-burst → burst completes at the old bank; next write goes to addr {1, 0}. Display vsync afterward → O_rd_bank=0, read addr {0, 0}.
- Write bursts totaling FRAME_WORDS with no vsync → next write addr offset 0, same bank.
- I_sdrc_rd_valid pulse while in IDLE → O_rd_fifo_wr stays 0 and O_err=1 and stays 1 until reset.
